bus_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits as a slave on the core's data bus, on the opposite side of the bus from the core. The core writes bytes into a small FIFO through a data register and polls a status register. The block serialises the queued bytes onto `datao` as 8N1 frames, LSB first, with line idle high. It is the core-driven output path for encoded JPEG data, in the opposite direction to the RAM-fed UART receive path.

---
 rtl/bus_uart_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// bus_uart_tx
// -----------------------------------------------------------------------------
// Memory-mapped UART transmitter that acts as a bus slave. The core pushes bytes
// into a small circular FIFO through the DATA register and polls STATUS. Queued
// bytes are sent on datao as 8N1 frames, LSB first, with the line idling high.
//
// Register map (word index = busaddr[3:2]):
//   0 DATA   : write pushes buswdata[7:0]; reads return 0
//   1 STATUS : bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky),
//              bits [8 +: log2(FIFODEPTH)+1] FIFO count; writing bit3=1 clears
//              overflow
//   2, 3     : read 0, writes ignored
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   busaddr   : slave address (only [3:2] decoded)
//   buswdata  : write data
//   buswrite  : write strobe
//   busrdata  : combinational read data
//   datao     : registered serial output
// -----------------------------------------------------------------------------
module bus_uart_tx #(
    parameter int CLKDIV    = 4,
    parameter int FIFODEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] busaddr,
    input  logic [31:0] buswdata,
    input  logic        buswrite,
    output logic [31:0] busrdata,
    output logic        datao
);

    localparam int AW = $clog2(FIFODEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKDIV);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKDIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFODEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    // Transmit FSM state and datapath
    state_t        r_state;
    state_t        w_state_next;
    logic          r_datao;
    logic          w_datao_next;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_next;
    logic [2:0]    r_bitcnt;
    logic [2:0]    w_bitcnt_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          w_pop;

    // Bus decode
    logic [1:0]    w_word;
    logic          w_push_req;
    logic          w_ovf_clr;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_drop;
    logic [7:0]    w_head;

    assign w_word     = busaddr[3:2];
    assign w_push_req = buswrite && (w_word == 2'd0);
    assign w_ovf_clr  = buswrite && (w_word == 2'd1) && buswdata[3];
    assign w_full     = (r_count == CW'(FIFODEPTH));
    assign w_empty    = (r_count == '0);
    // A pop on the same edge frees the slot the push needs, so a full FIFO
    // still accepts the byte in that case.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_head     = r_mem[r_rptr];

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wptr] <= buswdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A dropped push outranks a simultaneous clear request.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------- transmit FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_datao  <= 1'b1;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_datao  <= w_datao_next;
            r_baud   <= w_baud_next;
            r_bitcnt <= w_bitcnt_next;
            r_shift  <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_datao_next  = r_datao;
        w_baud_next   = r_baud;
        w_bitcnt_next = r_bitcnt;
        w_shift_next  = r_shift;
        w_pop         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_datao_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_datao_next = 1'b0;
                    w_baud_next  = BAUD_RELOAD;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_baud == '0) begin
                    w_datao_next  = r_shift[0];
                    w_bitcnt_next = 3'd0;
                    w_baud_next   = BAUD_RELOAD;
                    w_state_next  = ST_DATA;
                end else begin
                    w_baud_next = r_baud - BW'(1);
                end
            end
            ST_DATA: begin
                if (r_baud == '0) begin
                    w_baud_next = BAUD_RELOAD;
                    if (r_bitcnt == 3'd7) begin
                        w_datao_next = 1'b1;
                        w_state_next = ST_STOP;
                    end else begin
                        // Next bit is shift[1] before the shift takes effect.
                        w_shift_next  = {1'b0, r_shift[7:1]};
                        w_datao_next  = r_shift[1];
                        w_bitcnt_next = r_bitcnt + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud - BW'(1);
                end
            end
            ST_STOP: begin
                if (r_baud == '0) begin
                    if (!w_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_datao_next = 1'b0;
                        w_baud_next  = BAUD_RELOAD;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - BW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_datao_next = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------- read path
    always_comb begin
        busrdata = '0;
        if (w_word == 2'd1) begin
            busrdata[0]      = w_full;
            busrdata[1]      = w_empty;
            busrdata[2]      = (r_state != ST_IDLE);
            busrdata[3]      = r_ovf;
            busrdata[8 +: CW] = r_count;
        end
    end

    assign datao = r_datao;

endmodule

// File: tb/tb_bus_uart_tx.sv
`timescale 1ns/1ps
module tb_bus_uart_tx;

    localparam int CLKDIV    = 4;
    localparam int FIFODEPTH = 8;
    localparam int FRAME     = 10 * CLKDIV;
    localparam logic [31:0] ADDR_STATUS = 32'hABCD_0007; // word 1, junk elsewhere

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] busaddr = ADDR_STATUS;
    logic [31:0] buswdata = '0;
    logic        buswrite = 1'b0;
    logic [31:0] busrdata;
    logic        datao;

    bus_uart_tx #(.CLKDIV(CLKDIV), .FIFODEPTH(FIFODEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .busaddr  (busaddr),
        .buswdata (buswdata),
        .buswrite (buswrite),
        .busrdata (busrdata),
        .datao    (datao)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];     // bytes expected on the line, in order
    int         starts[$]; // cycle of each detected start edge
    int         m_frames = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  word;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] word, input logic [31:0] data);
        busaddr  = {28'hABCD_000, word, 2'b11};
        buswdata = data;
        buswrite = 1'b1;
        if (word == 2'd0 && !rst) sb.push_back(data[7:0]);
        tick();
        buswrite = 1'b0;
        busaddr  = ADDR_STATUS;
        #1;
    endtask

    // Same as bus_write but the byte is known to be dropped.
    task automatic bus_write_nosb(input logic [31:0] data);
        busaddr  = {28'hABCD_000, 2'd0, 2'b11};
        buswdata = data;
        buswrite = 1'b1;
        tick();
        buswrite = 1'b0;
        busaddr  = ADDR_STATUS;
        #1;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        busaddr = ADDR_STATUS;
        while (n < limit && !(sb.size() == 0 && busrdata == 32'h2)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending status 0x%08h required 0 and 0x00000002",
                     sb.size(), busrdata);
        end
    endtask

    // Serial line decoder: samples on the falling clock edge, checks each bit
    // level is flat for CLKDIV cycles, and compares bytes with the scoreboard.
    task automatic monitor();
        bit         active = 0;
        int         phase  = 0;
        logic       level  = 1'b0;
        bit         ok     = 1;
        logic [7:0] byte_v = '0;
        logic [7:0] exp_v;
        int         k;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
            end else if (!active) begin
                if (datao == 1'b0) begin
                    active = 1;
                    phase  = 0;
                    level  = 1'b0;
                    ok     = 1;
                    byte_v = '0;
                    starts.push_back(cyc);
                end
            end else begin
                phase++;
                k = phase / CLKDIV;
                if (phase % CLKDIV == 0) begin
                    level = datao;
                    if (k >= 1 && k <= 8) byte_v[k-1] = datao;
                    if (k == 9 && datao !== 1'b1) ok = 0;
                end else if (datao !== level) begin
                    ok = 0;
                end
                if (phase == FRAME - 1) begin
                    active = 0;
                    m_frames++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte 0x%02h required no frame", byte_v);
                    end else begin
                        exp_v = sb.pop_front();
                        chk("frame_byte", {23'd0, ok, byte_v}, {23'd0, 1'b1, exp_v});
                        $display("frame %0d: byte 0x%02h expected 0x%02h shape_ok=%0d",
                                 m_frames, byte_v, exp_v, ok);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [7:0] a5;
        logic       exp_bit;
        int         f0;

        vecs[0] = '{1'b0, 2'd1, 32'h0,         32'h0000_0002};
        vecs[1] = '{1'b0, 2'd0, 32'h0,         32'h0000_0000};
        vecs[2] = '{1'b0, 2'd2, 32'h0,         32'h0000_0000};
        vecs[3] = '{1'b0, 2'd3, 32'h0,         32'h0000_0000};
        vecs[4] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{1'b0, 2'd1, 32'h0,         32'h0000_0002};
        vecs[6] = '{1'b1, 2'd1, 32'hFFFF_FFF7, 32'h0000_0002};
        vecs[7] = '{1'b1, 2'd3, 32'h0000_00A5, 32'h0000_0000};

        fork
            monitor();
        join_none

        tick(); tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state and register map while idle
        chk("reset_status", busrdata, 32'h2);
        chk("reset_datao", {31'd0, datao}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            busaddr = {28'hABCD_000, vecs[i].word, 2'b11};
            if (vecs[i].wr) begin
                buswdata = vecs[i].wdata;
                buswrite = 1'b1;
                tick();
                buswrite = 1'b0;
            end
            #1;
            chk($sformatf("vec%0d_rdata", i), busrdata, vecs[i].exp);
            $display("vec %0d: wr=%0d word=%0d rdata=0x%08h", i, vecs[i].wr, vecs[i].word, busrdata);
        end
        busaddr = ADDR_STATUS;
        #1;
        chk("vec_status_after", busrdata, 32'h2);
        chk("vec_datao_after", {31'd0, datao}, 32'h1);

        // Single frame 0xA5 with per-cycle line check
        a5 = 8'hA5;
        bus_write(2'd0, 32'hA5);                   // edge 0
        chk("a5_count_edge0", busrdata, 32'h0000_0100);
        for (int e = 1; e <= 44; e++) begin
            tick();
            if (e <= 4)       exp_bit = 1'b0;
            else if (e <= 36) exp_bit = a5[(e - 5) / 4];
            else              exp_bit = 1'b1;
            chk($sformatf("a5_datao_e%0d", e), {31'd0, datao}, {31'd0, exp_bit});
            if (e == 1)  chk("a5_status_e1", busrdata, 32'h0000_0006);
            if (e == 40) chk("a5_busy_e40", {31'd0, busrdata[2]}, 32'h1);
            if (e == 41) chk("a5_busy_e41", {31'd0, busrdata[2]}, 32'h0);
        end
        wait_drain(200);

        // Back-to-back frames 0x00 then 0xFF
        starts.delete();
        bus_write(2'd0, 32'h00);                   // edge 0
        bus_write(2'd0, 32'hFF);                   // edge 1, pops 0x00
        tick();                                    // edge 2
        chk("b2b_status_count1", busrdata, 32'h0000_0104);
        wait_drain(300);
        chk("b2b_nframes", starts.size(), 2);
        if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], FRAME);

        // Overflow: 10 writes, 9 accepted; then push at full on a STOP->START pop
        for (int i = 0; i < 10; i++) begin         // edges 0..9
            if (i < 9) bus_write(2'd0, 32'h10 + i);
            else       bus_write_nosb(32'h10 + i);
        end
        chk("ovf_status_set", busrdata, 32'h0000_080D);
        bus_write(2'd1, 32'h8);                    // edge 10
        chk("ovf_status_clr", busrdata, 32'h0000_0805);
        for (int e = 11; e <= 40; e++) tick();
        chk("full_before_pop", busrdata, 32'h0000_0805);
        bus_write(2'd0, 32'h3C);                   // edge 41: pop + push at full
        chk("full_push_pop", busrdata, 32'h0000_0805);
        wait_drain(12 * FRAME);

        // Reset mid-frame discards the frame and the queue
        bus_write(2'd0, 32'h5A);
        bus_write(2'd0, 32'hC3);
        for (int e = 0; e < 14; e++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_datao", {31'd0, datao}, 32'h1);
        chk("midrst_status", busrdata, 32'h2);
        rst = 1'b0;
        sb.delete();
        f0 = m_frames;
        for (int e = 0; e < 3 * FRAME; e++) tick();
        chk("midrst_idle_datao", {31'd0, datao}, 32'h1);
        chk("midrst_idle_status", busrdata, 32'h2);
        chk("midrst_no_frames", m_frames - f0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
